// File: rtl/mux8_3to1_arb.sv
// Three-source round-robin merge into a single registered output slot.
// The slot reloads in the same cycle it drains, so a continuous stream moves one word per cycle.
module mux8_3to1_arb #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic             V1,
  input  logic             V2,
  input  logic             V3,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic [WIDTH-1:0] Q,
  output logic [1:0]       S,
  output logic             QV,
  input  logic             QR,
  output logic             dbg_full,
  output logic [1:0]       dbg_last
);

  // Handshake: a source raises Vn and holds In until An pulses; An is a
  // combinational one-cycle accept and In is captured on that same edge.
  // Downstream takes Q/S on any edge where QV and QR are both high.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_CH1  = 2'b01;
  localparam logic [1:0] CODE_CH2  = 2'b10;
  localparam logic [1:0] CODE_CH3  = 2'b11;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       last_q;
  logic [1:0]       s_q;
  logic [WIDTH-1:0] q_q;
  logic [1:0]       grant;
  logic [WIDTH-1:0] grant_data;
  logic             ld;
  logic             take;

  assign ld   = (state_q == EMPTY) || QR;
  assign take = ld && RST_N && (grant != CODE_NONE);

  // Search starts at the channel after the last one served; 00 behaves like ch3.
  always_comb begin
    grant = CODE_NONE;
    case (last_q)
      CODE_CH1: begin
        if (V2)      grant = CODE_CH2;
        else if (V3) grant = CODE_CH3;
        else if (V1) grant = CODE_CH1;
      end
      CODE_CH2: begin
        if (V3)      grant = CODE_CH3;
        else if (V1) grant = CODE_CH1;
        else if (V2) grant = CODE_CH2;
      end
      default: begin
        if (V1)      grant = CODE_CH1;
        else if (V2) grant = CODE_CH2;
        else if (V3) grant = CODE_CH3;
      end
    endcase
  end

  always_comb begin
    grant_data = I1;
    case (grant)
      CODE_CH2: grant_data = I2;
      CODE_CH3: grant_data = I3;
      default:  grant_data = I1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ld) begin
      state_d = take ? FULL : EMPTY;
    end
  end

  always_comb begin
    A1       = take && (grant == CODE_CH1);
    A2       = take && (grant == CODE_CH2);
    A3       = take && (grant == CODE_CH3);
    QV       = (state_q == FULL);
    dbg_full = (state_q == FULL);
  end

  // Q keeps its last word when the slot empties; only S is cleared.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_q    <= '0;
      s_q    <= CODE_NONE;
      last_q <= CODE_NONE;
    end else if (ld) begin
      if (take) begin
        q_q    <= grant_data;
        s_q    <= grant;
        last_q <= grant;
      end else begin
        s_q <= CODE_NONE;
      end
    end
  end

  assign Q        = q_q;
  assign S        = s_q;
  assign dbg_last = last_q;

endmodule

// File: tb/tb_mux8_3to1_arb.sv
// Directed bench for mux8_3to1_arb: inputs change on the falling edge,
// accepts are checked just after, registered outputs at the next falling edge.
module tb_mux8_3to1_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i1, i2, i3;
  logic       v1, v2, v3;
  logic       a1, a2, a3;
  logic [7:0] q;
  logic [1:0] s;
  logic       qv;
  logic       qr;
  logic       dbg_full;
  logic [1:0] dbg_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux8_3to1_arb #(.WIDTH(8)) dut (
    .CLK(clk), .RST_N(rst_n),
    .I1(i1), .I2(i2), .I3(i3),
    .V1(v1), .V2(v2), .V3(v3),
    .A1(a1), .A2(a2), .A3(a3),
    .Q(q), .S(s), .QV(qv), .QR(qr),
    .dbg_full(dbg_full), .dbg_last(dbg_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_acc(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, a3, a2, a1}, {29'd0, exp});
  endtask

  task automatic check_out(input string tag, input logic [7:0] eq, input logic [1:0] es,
                           input logic eqv);
    check({tag, "_q"}, {24'd0, q}, {24'd0, eq});
    check({tag, "_s"}, {30'd0, s}, {30'd0, es});
    check({tag, "_qv"}, {31'd0, qv}, {31'd0, eqv});
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rr_code [4];
    logic [7:0] rr_data [4];
    rr_code[0] = 2'b01; rr_code[1] = 2'b10; rr_code[2] = 2'b11; rr_code[3] = 2'b01;
    rr_data[0] = 8'h11; rr_data[1] = 8'h22; rr_data[2] = 8'h33; rr_data[3] = 8'h11;

    // Reset for two edges with every source asking
    rst_n = 1'b0; qr = 1'b1;
    v1 = 1'b1; v2 = 1'b1; v3 = 1'b1;
    i1 = 8'h11; i2 = 8'h22; i3 = 8'h33;
    for (int k = 0; k < 2; k++) begin
      settle();
      check_acc("rst_acc", 3'b000);
      check_out("rst", 8'h00, 2'b00, 1'b0);
    end

    // Round-robin from reset: ch1, ch2, ch3, ch1 on back-to-back cycles
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_acc("rr_acc", (rr_code[k] == 2'b01) ? 3'b001 :
                          (rr_code[k] == 2'b10) ? 3'b010 : 3'b100);
      settle();
      check_out("rr", rr_data[k], rr_code[k], 1'b1);
    end

    // Drain to empty: Q keeps its word, S clears
    v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    #1;
    check_acc("drain_acc", 3'b000);
    settle();
    check_out("drain", 8'h11, 2'b00, 1'b0);

    // Single source on ch2
    v2 = 1'b1; i2 = 8'h5A;
    #1;
    check_acc("single_acc", 3'b010);
    settle();
    check_out("single", 8'h5A, 2'b10, 1'b1);
    v2 = 1'b0;
    settle();
    check_out("single_drain", 8'h5A, 2'b00, 1'b0);

    // Load A0 from ch1, then hold under backpressure with ch3 waiting
    v1 = 1'b1; i1 = 8'hA0;
    #1;
    check_acc("bp_load_acc", 3'b001);
    settle();
    check_out("bp_load", 8'hA0, 2'b01, 1'b1);
    v1 = 1'b0; qr = 1'b0; v3 = 1'b1; i3 = 8'hC3;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_acc("bp_hold_acc", 3'b000);
      settle();
      check_out("bp_hold", 8'hA0, 2'b01, 1'b1);
    end
    qr = 1'b1;
    #1;
    check_acc("bp_release_acc", 3'b100);
    settle();
    check_out("bp_release", 8'hC3, 2'b11, 1'b1);

    // Reset while FULL and stalled: word discarded, no accept pulse
    qr = 1'b0; v1 = 1'b1; v3 = 1'b1; rst_n = 1'b0;
    #1;
    check_acc("rst_full_acc", 3'b000);
    settle();
    check_out("rst_full", 8'h00, 2'b00, 1'b0);

    // After release ch2 wins over ch3 since priority restarts at ch1
    rst_n = 1'b1; v1 = 1'b0; v2 = 1'b1; v3 = 1'b1; qr = 1'b1;
    i2 = 8'h77; i3 = 8'h99;
    #1;
    check_acc("post_rst_acc", 3'b010);
    settle();
    check_out("post_rst", 8'h77, 2'b10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
